// File: rtl/player_motion.sv
// Player motion controller: validates each direction request against the
// wall map (one read per move) and tracks position, goal and move count.
//
// Build option: PLAYER_MOTION_WRAP_EN -- when defined, moves off an edge
// wrap to the opposite edge and are wall-checked; otherwise they bump
// immediately without a wall read.
//
// Ports:
//   ClkPort, reset (async, active-high)
//   dir_pulse      {up, down, left, right} one-cycle requests
//   wall_rd        wall-map read strobe
//   wall_addr      cell index y*GRID_W+x
//   wall_q         wall bit, valid the cycle after wall_rd
//   player_x_pos   current cell x
//   player_y_pos   current cell y
//   busy           lookup/check in progress
//   moved, bumped  one-cycle move result pulses
//   at_goal        sticky goal flag
//   move_count     saturating count of completed moves
module player_motion #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 30,
  parameter int GOAL_Y  = 22
) (
  input  logic        ClkPort,
  input  logic        reset,
  input  logic [3:0]  dir_pulse,
  output logic        wall_rd,
  output logic [9:0]  wall_addr,
  input  logic        wall_q,
  output logic [7:0]  player_x_pos,
  output logic [7:0]  player_y_pos,
  output logic        busy,
  output logic        moved,
  output logic        bumped,
  output logic        at_goal,
  output logic [15:0] move_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    CHECK,
    DONE
  } state_t;

`ifdef PLAYER_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [7:0] XMAX = 8'(GRID_W - 1);
  localparam logic [7:0] YMAX = 8'(GRID_H - 1);
  localparam logic [9:0] W10  = 10'(GRID_W);
  localparam logic [7:0] SX   = 8'(START_X);
  localparam logic [7:0] SY   = 8'(START_Y);
  localparam logic [7:0] GX   = 8'(GOAL_X);
  localparam logic [7:0] GY   = 8'(GOAL_Y);

  state_t     state;
  logic [7:0] tgt_x;
  logic [7:0] tgt_y;

  logic [7:0] nx;
  logic [7:0] ny;
  logic       off_edge;
  logic [9:0] naddr;

  // Candidate target; on an edge the wrapped cell is produced and
  // off_edge flags it so the no-wrap build can bump instead.
  always_comb begin
    nx       = player_x_pos;
    ny       = player_y_pos;
    off_edge = 1'b0;
    priority case (1'b1)
      dir_pulse[3]: begin
        if (player_y_pos == 8'd0) begin
          off_edge = 1'b1;
          ny       = YMAX;
        end else begin
          ny = player_y_pos - 8'd1;
        end
      end
      dir_pulse[2]: begin
        if (player_y_pos == YMAX) begin
          off_edge = 1'b1;
          ny       = 8'd0;
        end else begin
          ny = player_y_pos + 8'd1;
        end
      end
      dir_pulse[1]: begin
        if (player_x_pos == 8'd0) begin
          off_edge = 1'b1;
          nx       = XMAX;
        end else begin
          nx = player_x_pos - 8'd1;
        end
      end
      dir_pulse[0]: begin
        if (player_x_pos == XMAX) begin
          off_edge = 1'b1;
          nx       = 8'd0;
        end else begin
          nx = player_x_pos + 8'd1;
        end
      end
      default: ;
    endcase
    naddr = 10'(ny) * W10 + 10'(nx);
  end

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tgt_x        <= SX;
      tgt_y        <= SY;
      player_x_pos <= SX;
      player_y_pos <= SY;
      move_count   <= 16'd0;
      at_goal      <= 1'b0;
      busy         <= 1'b0;
      moved        <= 1'b0;
      bumped       <= 1'b0;
      wall_rd      <= 1'b0;
      wall_addr    <= 10'd0;
    end else begin
      moved   <= 1'b0;
      bumped  <= 1'b0;
      wall_rd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|dir_pulse && !at_goal) begin
            tgt_x <= nx;
            tgt_y <= ny;
            if (off_edge && !WRAP) begin
              bumped <= 1'b1;
              state  <= DONE;
            end else begin
              wall_rd   <= 1'b1;
              wall_addr <= naddr;
              busy      <= 1'b1;
              state     <= LOOKUP;
            end
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          busy  <= 1'b0;
          state <= DONE;
          if (!wall_q) begin
            player_x_pos <= tgt_x;
            player_y_pos <= tgt_y;
            moved        <= 1'b1;
            if (move_count != 16'hFFFF)
              move_count <= move_count + 16'd1;
            if (tgt_x == GX && tgt_y == GY)
              at_goal <= 1'b1;
          end else begin
            bumped <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter GRID_W, default 32, maze width in cells.
REQ-002 SHALL have parameter GRID_H, default 24, maze height in cells.
REQ-003 SHALL have parameters START_X/START_Y, defaults 1/1, reset cell, and GOAL_X/GOAL_Y, defaults 30/22, goal cell.
REQ-004 SHALL have ports: ClkPort  in  1  system clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dir_pulse  in  4  one-cycle debounced requests {up, down, left, right}.
REQ-006 SHALL have ports wall_rd  out  1  wall-map read strobe; wall_addr  out  10  cell index y*GRID_W+x.
REQ-007 SHALL have port wall_q  in  1  wall bit (1 = wall), valid the cycle after wall_rd.
REQ-008 SHALL have ports player_x_pos  out  8  and player_y_pos  out  8, current cell.
REQ-009 SHALL have ports busy  out  1, moved  out  1 (pulse), bumped  out  1 (pulse), at_goal  out  1, move_count  out  16.

Function
REQ-010 SHALL implement states IDLE, LOOKUP, CHECK, DONE.
REQ-011 IDLE: a nonzero dir_pulse in cycle N SHALL be accepted; the target cell is latched; next state is LOOKUP.
REQ-012 When several dir_pulse bits are set, priority SHALL be up > down > left > right; up decrements y, down increments y, left decrements x, right increments x.
REQ-013 dir_pulse SHALL be ignored in LOOKUP, CHECK and DONE, and whenever at_goal=1; ignored requests are not queued.
REQ-014 LOOKUP (cycle N+1): wall_rd=1 and wall_addr=target index for exactly one cycle; busy=1.
REQ-015 CHECK (cycle N+2): wall_q sampled; busy=1; if wall_q=0 position updates to target, else position unchanged.
REQ-016 DONE (cycle N+3): new position visible; exactly one of moved/bumped high for this cycle; busy=0; next state IDLE; a pulse is next accepted at N+4.
REQ-017 wall_rd SHALL be 0 and wall_addr SHALL hold its last value outside LOOKUP.
REQ-018 move_count SHALL increment by 1 on every moved pulse and saturate at 16'hFFFF.
REQ-019 at_goal SHALL go high in the cycle position equals (GOAL_X, GOAL_Y) and remain high until reset.
REQ-020 Boundary moves (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down) SHALL follow REQ-029/REQ-030.
REQ-021 wall_addr arithmetic SHALL be performed at 10 bits; GRID_W*GRID_H SHALL NOT exceed 1024.

Reset
REQ-022 reset SHALL act immediately regardless of clock, including mid-move.
REQ-023 On reset: state IDLE, position (START_X, START_Y), move_count 0, at_goal 0, busy 0, moved 0, bumped 0, wall_rd 0, wall_addr 0.
REQ-024 A pending lookup aborted by reset SHALL NOT update position or counters; wall_q after reset is ignored.
REQ-025 First request SHALL be accepted in the first clock edge after reset deasserts.

Configuration
REQ-026 Macro PLAYER_MOTION_WRAP_EN SHALL select edge behaviour.
REQ-027 Defined: off-edge target wraps (x=0 left -> GRID_W-1; y=GRID_H-1 down -> 0), then normal LOOKUP/CHECK.
REQ-028 Undefined: off-edge request skips LOOKUP/CHECK; bumped pulses at N+1, no wall_rd, position unchanged, IDLE at N+2.
REQ-029 With wrap enabled, wrapped cells are subject to the wall check like any other target.
REQ-030 Configuration SHALL NOT change port list, reset values or in-grid timing.

Verification
REQ-031 Reset, pulse right at (1,1), wall_q=0 -> wall_rd at N+1 with wall_addr=34, position (2,1) and moved=1 at N+3, move_count=1.
REQ-032 Pulse up at (2,1), wall_q=1 -> wall_addr=2, bumped=1 at N+3, position stays (2,1), move_count unchanged.
REQ-033 dir_pulse=4'b1111 at IDLE -> up chosen; second pulse at N+1 ignored; only one wall_rd.
REQ-034 At (0,5) pulse left: WRAP_EN undefined -> bumped at N+1, no wall_rd; defined -> wall_addr=191, wall_q=0 gives (31,5).
REQ-035 Reach (30,22) -> at_goal=1; subsequent pulses produce no wall_rd; reset returns (1,1), at_goal=0.
REQ-036 Assert reset during CHECK -> position (1,1), no moved/bumped pulse, move_count 0.
